// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter with a one-byte holding register.
//
// Sits directly downstream of the typing-test core. The core strobes tx_go
// with tx_byte. If the line is idle, the byte starts a frame at once.
// Otherwise the byte waits in the holding register, so the next frame
// follows the current one with only the single CLEANUP cycle between them.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit (>= 2), 434 = 50 MHz / 115200
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous, active-high reset
//   tx_go      - byte-valid strobe from the core
//   tx_byte    - byte to send, valid with tx_go
//   tx_ready   - holding register empty; a tx_go this cycle is accepted
//   tx_active  - frame in progress (START, DATA, STOP or CLEANUP)
//   tx_serial  - UART line, idle high, registered
//   tx_done    - one-cycle pulse in the CLEANUP cycle after the stop bit
//   tx_overrun - one-cycle pulse after a tx_go that arrived while tx_ready=0
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_go,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done,
  output logic       tx_overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       hold_reg;
  logic             hold_vld;

  logic             accept;
  logic             bit_end;
  logic             load_direct;
  logic             load_hold;
  logic             write_hold;

  // tx_ready mirrors !hold_vld, so in CLEANUP an accepted tx_go always means
  // the holding register is empty and the byte can go straight to the shifter.
  assign accept      = tx_go & tx_ready;
  assign bit_end     = (clk_cnt == CNT_LAST);
  assign load_direct = accept & ((state == IDLE) | (state == CLEANUP));
  assign load_hold   = (state == CLEANUP) & hold_vld;
  assign write_hold  = accept & (state != IDLE) & (state != CLEANUP);

  // Byte storage: contents only matter while the matching valid/state says so.
  always_ff @(posedge clk) begin
    if (load_hold) begin
      shift_reg <= hold_reg;
    end else if (load_direct) begin
      shift_reg <= tx_byte;
    end
    if (write_hold) begin
      hold_reg <= tx_byte;
    end
  end

  // Frame sequencing with registered line and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      hold_vld   <= 1'b0;
      tx_ready   <= 1'b1;
      tx_active  <= 1'b0;
      tx_serial  <= 1'b1;
      tx_done    <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      tx_done    <= 1'b0;
      tx_overrun <= tx_go & ~tx_ready;

      if (write_hold) begin
        hold_vld <= 1'b1;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_cnt   <= '0;
          bit_idx   <= '0;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
          if (load_direct) begin
            state     <= START;
            tx_serial <= 1'b0;
            tx_active <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            tx_serial <= shift_reg[0];
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state     <= STOP;
              tx_serial <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= CLEANUP;
            tx_done <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        CLEANUP: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (hold_vld) begin
            hold_vld  <= 1'b0;
            tx_ready  <= 1'b1;
            state     <= START;
            tx_serial <= 1'b0;
          end else if (load_direct) begin
            state     <= START;
            tx_serial <= 1'b0;
          end else begin
            state     <= IDLE;
            tx_active <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
